// File: rtl/input_conditioner_pkg.sv
// Shared machine package: debounce defaults, counter width, x packing.
// x layout is {sw_level[3:0], btn_level[3:0]}.
package input_conditioner_pkg;

  localparam int unsigned DEBOUNCE_DEFAULT = 50000;
  localparam int unsigned CNT_W = 16;

  localparam int unsigned N_SW = 4;
  localparam int unsigned N_BTN = 4;
  localparam int unsigned X_W = N_SW + N_BTN;

  localparam int unsigned BTN_LSB = 0;
  localparam int unsigned SW_LSB = N_BTN;

  function automatic logic [X_W-1:0] pack_x(
    input logic [N_SW-1:0] sw,
    input logic [N_BTN-1:0] btn
  );
    return {sw, btn};
  endfunction

endpackage

// File: rtl/debounce_bit.sv
// One input bit: synchronizer chain, debounce counter, level, edge pulses.
// Ports: clk_i, rst_i (sync, high), raw_i -> lvl_o, rise_o, fall_o.
module debounce_bit
  import input_conditioner_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic raw_i,
  output logic lvl_o,
  output logic rise_o,
  output logic fall_o
);

  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic lvl_q, lvl_d;
  logic rise_q, rise_d;
  logic fall_q, fall_d;
  logic sync_out, differ, accept;

  assign sync_out = sync_q[SYNC_STAGES-1];

  always_comb begin
    differ = sync_out ^ lvl_q;
    accept = differ && (cnt_q == CNT_MAX);
    cnt_d = '0;
    lvl_d = lvl_q;
    rise_d = 1'b0;
    fall_d = 1'b0;
    // Any agreeing cycle restarts the count.
    if (differ && !accept) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    if (accept) begin
      lvl_d = sync_out;
      rise_d = sync_out;
      fall_d = ~sync_out;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
      cnt_q <= '0;
      lvl_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      if (SYNC_STAGES > 1) begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
      end else begin
        sync_q <= raw_i;
      end
      cnt_q <= cnt_d;
      lvl_q <= lvl_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign lvl_o = lvl_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/input_conditioner.sv
// Debounces 4 switches and 4 buttons; packs levels and routes edge pulses.
// Ports: system1000/_rst, Sw, Btn -> x, btn_press, btn_release, sw_change.
module input_conditioner
  import input_conditioner_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic             system1000,
  input  logic             system1000_rst,
  input  logic [N_SW-1:0]  Sw,
  input  logic [N_BTN-1:0] Btn,
  output logic [X_W-1:0]   x,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_SW-1:0]  sw_change
);

  logic [X_W-1:0] raw;
  logic [X_W-1:0] lvl;
  logic [X_W-1:0] rise;
  logic [X_W-1:0] fall;

  assign raw = pack_x(Sw, Btn);

  for (genvar i = 0; i < X_W; i++) begin : g_bit
    debounce_bit #(
      .SYNC_STAGES(SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_bit (
      .clk_i(system1000),
      .rst_i(system1000_rst),
      .raw_i(raw[i]),
      .lvl_o(lvl[i]),
      .rise_o(rise[i]),
      .fall_o(fall[i])
    );
  end

  assign x = lvl;
  assign btn_press = rise[BTN_LSB +: N_BTN];
  assign btn_release = fall[BTN_LSB +: N_BTN];
  assign sw_change = rise[SW_LSB +: N_SW] | fall[SW_LSB +: N_SW];

endmodule

// File: doc/input_conditioner.md
INPUT_CONDITIONER -- requirements
Module: input_conditioner

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, synchronizer depth per input bit (legal range 2..4).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 50000, the number of consecutive cycles of disagreement required to accept a new level (legal range 2..65535).
REQ-003 SHALL have input system1000, 1 bit, the single system clock; all logic SHALL be clocked on its rising edge.
REQ-004 SHALL have input system1000_rst, 1 bit; reset is synchronous and active-high.
REQ-005 SHALL have input Sw, 4 bits, raw asynchronous slide switches.
REQ-006 SHALL have input Btn, 4 bits, raw asynchronous push buttons.
REQ-007 SHALL have output x, 8 bits, debounced levels packed {sw_level, btn_level}; this feeds the machine input directly.
REQ-008 SHALL have output btn_press, 4 bits, a one-cycle pulse on each debounced 0->1 transition of a button.
REQ-009 SHALL have output btn_release, 4 bits, a one-cycle pulse on each debounced 1->0 transition of a button.
REQ-010 SHALL have output sw_change, 4 bits, a one-cycle pulse on any debounced switch transition.

Function
REQ-011 Each of the 8 raw bits (Sw[3:0], Btn[3:0]) SHALL pass through an independent SYNC_STAGES-deep flop chain; no logic SHALL sit between synchronizer stages.
REQ-012 Each bit SHALL have a debounced level register "lvl" and a 16-bit counter "cnt".
REQ-013 When sync_out == lvl, cnt SHALL clear to 0.
REQ-014 When sync_out != lvl and cnt < DEBOUNCE_CYCLES-1, cnt SHALL increment by 1.
REQ-015 When sync_out != lvl and cnt == DEBOUNCE_CYCLES-1, lvl SHALL take sync_out and cnt SHALL clear to 0 on that same edge.
REQ-016 A glitch shorter than DEBOUNCE_CYCLES cycles at sync_out SHALL leave lvl unchanged; any single agreeing cycle SHALL restart the count from 0.
REQ-017 Total latency from a clean raw edge to the x change SHALL be exactly SYNC_STAGES + DEBOUNCE_CYCLES rising edges.
REQ-018 btn_press[i] SHALL be 1 for exactly the one cycle following the edge at which lvl of Btn[i] goes 0->1.
REQ-019 btn_release[i] SHALL behave as btn_press[i] for the 1->0 transition.
REQ-020 sw_change[i] SHALL behave as btn_press[i] for either transition of Sw[i].
REQ-021 All pulse outputs SHALL be registered, and no two pulses SHALL be generated for one lvl transition.
REQ-022 Bits SHALL be fully independent; simultaneous transitions on several bits SHALL produce simultaneous pulses.
REQ-023 cnt SHALL never exceed DEBOUNCE_CYCLES-1 (no wrap-around).

Reset
REQ-024 While system1000_rst is 1 at a rising edge, all synchronizer flops, lvl, cnt and pulse registers SHALL clear to 0; x, btn_press, btn_release and sw_change SHALL read 0 the following cycle.
REQ-025 Reset asserted mid-count SHALL discard the partial count.
REQ-026 After reset deassertion, no pulse SHALL be generated for an input held at 0.
REQ-027 An input held at 1 through reset SHALL be accepted through the normal path, producing one press/change pulse SYNC_STAGES + DEBOUNCE_CYCLES cycles after reset is released.

Structure
REQ-028 DEBOUNCE_CYCLES default, counter width (16) and the x packing order SHALL live in the shared machine package.
REQ-029 One sub-module, debounce_bit (synchronizer + counter + lvl + rise/fall pulses), SHALL be instantiated 8 times; the top SHALL only pack and route.

Verification (benches SHALL use DEBOUNCE_CYCLES=4, SYNC_STAGES=2)
REQ-030 Reset, then Btn=4'b0001 held -> x=8'h01 exactly 6 edges after the change; btn_press=4'b0001 for 1 cycle; no further pulses.
REQ-031 Btn[2] bounce pattern 1,0,1,1,0,1,1,1,1 (per cycle) -> lvl accepted only after the final run of 4 consecutive 1s at sync_out; exactly one btn_press[2] pulse.
REQ-032 3-cycle high glitch on Sw[3] -> x unchanged; sw_change stays 0.
REQ-033 Sw=4'hF and Btn=4'hF changed on the same cycle -> x=8'hFF after 6 edges; sw_change=4'hF and btn_press=4'hF on the same cycle.
REQ-034 Btn[1] high, reset pulsed after 3 cycles of count -> after release, x[1] rises at 6 edges post-reset, not earlier.
REQ-035 Btn=4'b1000 press then release, each held 10 cycles -> one btn_press[3] pulse, then one btn_release[3] pulse, 10 cycles apart.
